// File: rtl/crypto_pkg.sv
// Shared types and defaults for the byte-stream XOR cipher: FSM encoding,
// byte width and the default LFSR feedback / zero-key substitution values.
package crypto_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] LFSR_TAPS_DEF = 8'hB8;
    localparam logic [BYTE_W-1:0] ZERO_SUB_DEF  = 8'h01;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        IDLE  = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/bitwise_xor.sv
// Combinational W-bit bitwise XOR core.
module bitwise_xor #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_keystream_lfsr.sv
// 8-bit Galois LFSR keystream: seed load has priority over advance, and a
// zero seed is replaced so the register can never lock up at all-zeros.
module xor_keystream_lfsr
    import crypto_pkg::*;
#(
    parameter logic [BYTE_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF,
    parameter logic [BYTE_W-1:0] ZERO_SUB  = ZERO_SUB_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              advance,
    output logic [BYTE_W-1:0] ks
);
    logic [BYTE_W-1:0] ks_step;

    assign ks_step = {1'b0, ks[BYTE_W-1:1]} ^ (ks[0] ? LFSR_TAPS : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks <= '0;
        end else if (load) begin
            ks <= (seed == '0) ? ZERO_SUB : seed;
        end else if (advance) begin
            ks <= ks_step;
        end
    end
endmodule

// File: rtl/xor_cipher_ctrl.sv
// Byte-stream cipher controller: valid/ready in, registered valid/ready out,
// each accepted byte XORed with the current LFSR keystream byte.
module xor_cipher_ctrl
    import crypto_pkg::*;
#(
    parameter logic [BYTE_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF,
    parameter logic [BYTE_W-1:0] ZERO_SUB  = ZERO_SUB_DEF,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [BYTE_W-1:0] key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              key_ok,
    output logic [CNT_W-1:0]  byte_cnt
);
    state_t            state, state_nxt;
    logic              accept;
    logic [BYTE_W-1:0] ks;
    logic [BYTE_W-1:0] xor_y;

    assign out_valid = (state == HOLD);
    // key_load blocks acceptance so a reload never consumes a byte with the old key
    assign in_ready  = key_ok & ~key_load & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    xor_keystream_lfsr #(
        .LFSR_TAPS (LFSR_TAPS),
        .ZERO_SUB  (ZERO_SUB)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (key_load),
        .seed    (key_in),
        .advance (accept),
        .ks      (ks)
    );

    bitwise_xor #(
        .W (BYTE_W)
    ) u_xor (
        .a (in_data),
        .b (ks),
        .y (xor_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOKEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (key_load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                NOKEY:   state_nxt = NOKEY;
                IDLE:    if (accept) state_nxt = HOLD;
                HOLD:    if (out_ready && !accept) state_nxt = IDLE;
                default: state_nxt = NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            byte_cnt <= '0;
            key_ok   <= 1'b0;
        end else if (key_load) begin
            byte_cnt <= '0;
            key_ok   <= 1'b1;
        end else if (accept) begin
            out_data <= xor_y;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Directed self-checking bench for xor_cipher_ctrl with hand-computed vectors.
module tb_xor_cipher_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_load = 1'b0;
    logic [7:0]  key_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        key_ok;
    logic [15:0] byte_cnt;

    int errors = 0;
    int checks = 0;

    xor_cipher_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .key_ok    (key_ok),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        step();
        key_load = 1'b0;
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_load  = 1'($urandom);
            key_in    = 8'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || key_ok !== 1'b0 ||
                byte_cnt !== 16'd0 || out_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got ov=%b ir=%b ko=%b cnt=%0d od=%h required 0 0 0 0 00",
                         i, out_valid, in_ready, key_ok, byte_cnt, out_data);
            end
        end
        key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_in = '0; in_data = '0;
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [7:0] din [3] = '{8'hAA, 8'h55, 8'h00};
        logic [7:0] exp [3] = '{8'hAB, 8'hED, 8'h5C};
        out_ready = 1'b1;
        load_key(8'h01);
        checks++;
        if (key_ok !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_keyok: got ko=%b ir=%b required 1 1", key_ok, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL stream_byte%0d: got ov=%b od=%h required 1 %h", i, out_valid, out_data, exp[i]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (byte_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stream_cnt: got %0d required 3", byte_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        load_key(8'h01);
        send(8'hAA);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hAB || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: got ov=%b od=%h ir=%b required 1 AB 0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hED || byte_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_resume: got ov=%b od=%h cnt=%0d required 1 ED 2", out_valid, out_data, byte_cnt);
        end
        step();
    endtask

    task automatic test_zero_key();
        out_ready = 1'b1;
        load_key(8'h00);
        send(8'h00);
        checks++;
        if (out_data !== 8'h01) begin
            errors++;
            $display("FAIL zero_key: got %h required 01", out_data);
        end
        load_key(8'h01);
        send(8'h00);
        checks++;
        if (out_data !== 8'h01) begin
            errors++;
            $display("FAIL key01_match: got %h required 01", out_data);
        end
        step();
    endtask

    task automatic test_reload();
        out_ready = 1'b0;
        load_key(8'h01);
        send(8'hAA);
        in_valid = 1'b1;
        in_data  = 8'h33;
        out_ready = 1'b1;
        key_load = 1'b1;
        key_in   = 8'h5C;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_blocks_accept: got ir=%b required 0", in_ready);
        end
        step();
        key_load = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || byte_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reload_discard: got ov=%b cnt=%0d required 0 0", out_valid, byte_cnt);
        end
        out_ready = 1'b1;
        send(8'h0F);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h53) begin
            errors++;
            $display("FAIL reload_new_key: got ov=%b od=%h required 1 53", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] plain [8] = '{8'h00, 8'hFF, 8'hAA, 8'h55, 8'h12, 8'h34, 8'hC3, 8'h7E};
        logic [7:0] ct [8];
        out_ready = 1'b1;
        load_key(8'h3C);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = plain[i];
            step();
            ct[i] = out_data;
        end
        in_valid = 1'b0;
        checks++;
        if (ct[0] !== 8'h3C || ct[1] !== 8'hE1 || byte_cnt !== 16'd8) begin
            errors++;
            $display("FAIL rt_cipher: got c0=%h c1=%h cnt=%0d required 3C E1 8", ct[0], ct[1], byte_cnt);
        end
        load_key(8'h3C);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = ct[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== plain[i]) begin
                errors++;
                $display("FAIL rt_plain%0d: got ov=%b od=%h required 1 %h", i, out_valid, out_data, plain[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        load_key(8'h01);
        send(8'hAA);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || key_ok !== 1'b0 || byte_cnt !== 16'd0 ||
            out_data !== 8'h00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ov=%b ko=%b cnt=%0d od=%h ir=%b required 0 0 0 00 0",
                     out_valid, key_ok, byte_cnt, out_data, in_ready);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'h11);
        checks++;
        if (out_valid !== 1'b0 || byte_cnt !== 16'd0) begin
            errors++;
            $display("FAIL nokey_reject: got ov=%b cnt=%0d required 0 0", out_valid, byte_cnt);
        end
        load_key(8'h01);
        send(8'hAA);
        checks++;
        if (out_data !== 8'hAB) begin
            errors++;
            $display("FAIL after_reset_key: got %h required AB", out_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_key();
        test_reload();
        test_back_to_back();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
